// File: rtl/instr_feeder.sv
// Program sequencer feeding the 9-bit bus processor: loadable program memory, PC, Run/Done handshake.
// Optional WAIT watchdog is enabled with `define INSTR_FEEDER_WATCHDOG_EN.
module instr_feeder #(
    parameter int unsigned N       = 9,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          LdEn,
    input  logic [AW-1:0] LdAddr,
    input  logic [N-1:0]  LdData,
    output logic [N-1:0]  DIN,
    output logic          Run,
    input  logic          Done,
    output logic [AW-1:0] PC,
    output logic          Busy,
    output logic          Halted,
    output logic          Error,
    output logic [2:0]    DbgState
);

    // Handshake: Run stays high from ISSUE until the cycle Done is sampled in WAIT;
    // Done is only honoured while Run is high, and Run drops on the edge that samples it.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_ISSUE     = 3'd4,
        S_WAIT      = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [2:0]    OP_MVI  = 3'b001;
    localparam logic [2:0]    OP_HALT = 3'b111;
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
    localparam logic [AW:0]   LAST_W  = (AW + 1)'(DEPTH - 1);

    if (TIMEOUT < 1 || (64'd1 << AW) < 64'(DEPTH)) begin : g_bad_cfg
        $error("instr_feeder: need TIMEOUT >= 1 and 2**AW >= DEPTH");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [N-1:0]  din_q, din_d;
    logic          run_q, run_d;
    logic          err_q, err_d;
    logic [N-1:0]  instr_q, instr_d;
    logic [N-1:0]  imm_q, imm_d;

    logic [N-1:0]  mem [DEPTH];
    logic [N-1:0]  rd_q;
    logic [AW-1:0] rd_addr;
    logic          ld_ok;
    logic [2:0]    rd_op;
    logic          instr_mvi;
    logic [AW:0]   pc_sum;
    logic          wd_timeout;

    assign ld_ok     = LdEn && (state_q == S_IDLE || state_q == S_HALT) && (32'(LdAddr) < DEPTH);
    assign rd_addr   = (state_q == S_DECODE) ? pc_q + AW'(1) : pc_q;
    assign rd_op     = rd_q[N-1 -: 3];
    assign instr_mvi = (instr_q[N-1 -: 3] == OP_MVI);
    assign pc_sum    = {1'b0, pc_q} + (instr_mvi ? (AW + 1)'(2) : (AW + 1)'(1));

    // Program memory is deliberately not reset.
    always_ff @(posedge Clock) begin
        if (ld_ok) begin
            mem[LdAddr] <= LdData;
        end
        rd_q <= mem[rd_addr];
    end

`ifdef INSTR_FEEDER_WATCHDOG_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_q, wd_d;

    // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
    assign wd_d       = (state_q == S_WAIT) ? wd_q + CW'(1) : '0;
    assign wd_timeout = (wd_q == CW'(TIMEOUT - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            run_q   <= run_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        run_d   = run_q;
        err_d   = err_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                instr_d = rd_q;
                if (rd_op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (rd_op == OP_MVI) begin
                    // An mvi in the last slot has no immediate to fetch.
                    if (pc_q == LAST_A) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_FETCH_IMM;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FETCH_IMM: begin
                imm_d   = rd_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                din_d   = instr_q;
                run_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (instr_mvi) begin
                    din_d = imm_q;
                end
                if (Done) begin
                    run_d = 1'b0;
                    if (pc_sum > LAST_W) begin
                        pc_d    = LAST_A;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_sum[AW-1:0];
                        state_d = S_FETCH;
                    end
                end else if (wd_timeout) begin
                    run_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign DIN      = din_q;
    assign Run      = run_q;
    assign PC       = pc_q;
    assign Error    = err_q;
    assign Halted   = (state_q == S_HALT);
    assign Busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign DbgState = state_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: random and directed programs checked against a program-level reference model.
module tb_instr_feeder;

  localparam int N = 9;
  localparam int DEPTH = 32;
  localparam int AW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic          LdEn;
  logic [AW-1:0] LdAddr;
  logic [N-1:0]  LdData;
  logic [N-1:0]  DIN;
  logic          Run;
  logic          Done;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [2:0]    DbgState;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] mem_m [DEPTH];
  logic [N-1:0] exp_q [$];
  int           exp_pc_q [$];
  int           fin_pc;
  int           fin_err;

  instr_feeder dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .LdEn(LdEn), .LdAddr(LdAddr),
    .LdData(LdData), .DIN(DIN), .Run(Run), .Done(Done), .PC(PC), .Busy(Busy),
    .Halted(Halted), .Error(Error), .DbgState(DbgState)
  );

  // clock / reset
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rand_word(input bit single_only);
    int op;
    if (single_only) begin
      op = $urandom_range(0, 5);
      if (op >= 1) op = op + 1;
    end else begin
      op = $urandom_range(0, 7);
      if (op == 7 && $urandom_range(0, 2) != 0) op = 2;
    end
    return {3'(op), 6'($urandom_range(0, 63))};
  endfunction

  // Reference model: walk the program by its opcode rules, listing every word handed to the processor.
  task automatic build_model();
    int pc = 0;
    int len;
    logic [2:0] op;
    exp_q.delete();
    exp_pc_q.delete();
    fin_err = 0;
    fin_pc = 0;
    for (int step = 0; step < 64; step++) begin
      op = mem_m[pc][8:6];
      if (op == 3'b111) begin
        fin_pc = pc;
        break;
      end
      if (op == 3'b001 && pc == DEPTH - 1) begin
        fin_pc = pc;
        fin_err = 1;
        break;
      end
      exp_q.push_back(mem_m[pc]);
      exp_pc_q.push_back(pc);
      len = 1;
      if (op == 3'b001) begin
        exp_q.push_back(mem_m[pc + 1]);
        len = 2;
      end
      if (pc + len > DEPTH - 1) begin
        fin_pc = DEPTH - 1;
        break;
      end
      pc = pc + len;
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge Clock);
      LdEn = 1'b1;
      LdAddr = AW'(i);
      LdData = mem_m[i];
    end
    @(negedge Clock);
    LdEn = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Start (optionally with a simultaneous write to address 0), then play processor for every expected word.
  task automatic run_program(input string tag, input bit swl, input logic [N-1:0] w0,
                             input bit poke, input bit spur_en);
    logic [N-1:0] instr, imm, want;
    int pc_e, lat, d, cnt;
    bit mvi, spur, saw_run, first;
    if (swl) mem_m[0] = w0;
    build_model();
    @(negedge Clock);
    Start = 1'b1;
    if (swl) begin
      LdEn = 1'b1;
      LdAddr = '0;
      LdData = w0;
    end
    @(negedge Clock);
    Start = 1'b0;
    LdEn = 1'b0;
    first = 1'b1;
    while (exp_q.size() > 0) begin
      instr = exp_q.pop_front();
      pc_e = exp_pc_q.pop_front();
      mvi = (instr[8:6] == 3'b001);
      imm = mvi ? exp_q.pop_front() : instr;
      lat = 0;
      spur = spur_en && !first && ($urandom_range(0, 2) == 0);
      if (spur) begin
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        lat = 1;
      end
      while (!Run && lat < 20) begin
        @(negedge Clock);
        lat++;
      end
      chk({tag, "_latency"}, lat, mvi ? 4 : 3);
      if (!Run) begin
        do_reset();
        return;
      end
      chk({tag, "_din_issue"}, 32'(DIN), 32'(instr));
      chk({tag, "_pc"}, 32'(PC), pc_e);
      chk({tag, "_busy"}, 32'(Busy), 1);
      if (poke && first) begin
        LdEn = 1'b1;
        LdAddr = AW'($urandom_range(0, DEPTH - 1));
        LdData = ~mem_m[LdAddr];
        @(negedge Clock);
        LdEn = 1'b0;
      end
      d = mvi ? $urandom_range(1, 4) : $urandom_range(0, 4);
      repeat (d) @(negedge Clock);
      want = mvi ? imm : instr;
      chk({tag, "_din_wait"}, 32'(DIN), 32'(want));
      chk({tag, "_run_wait"}, 32'(Run), 1);
      Done = 1'b1;
      @(negedge Clock);
      Done = 1'b0;
      chk({tag, "_run_drop"}, 32'(Run), 0);
      first = 1'b0;
    end
    cnt = 0;
    saw_run = 1'b0;
    while (!Halted && cnt < 20) begin
      saw_run |= Run;
      @(negedge Clock);
      cnt++;
    end
    saw_run |= Run;
    chk({tag, "_no_extra_run"}, 32'(saw_run), 0);
    chk({tag, "_halted"}, 32'(Halted), 1);
    chk({tag, "_final_pc"}, 32'(PC), fin_pc);
    chk({tag, "_error"}, 32'(Error), fin_err);
    chk({tag, "_busy_end"}, 32'(Busy), 0);
  endtask

  task automatic wait_run(input string tag);
    int lat = 0;
    while (!Run && lat < 20) begin
      @(negedge Clock);
      lat++;
    end
    chk({tag, "_run_seen"}, 32'(Run), 1);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1;
    Start = 1'b0;
    LdEn = 1'b0;
    LdAddr = '0;
    LdData = '0;
    Done = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    chk("rst_din", 32'(DIN), 0);
    chk("rst_run", 32'(Run), 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_halted", 32'(Halted), 0);
    chk("rst_error", 32'(Error), 0);
    chk("rst_state", 32'(DbgState), 0);

    // add then halt; address 0 written together with Start
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 9'o700;
    load_all();
    mem_m[1] = 9'o700;
    run_program("add_halt", 1'b1, 9'o012, 1'b0, 1'b0);

    // mvi with immediate
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 9'o700;
    mem_m[0] = 9'o100;
    mem_m[1] = 9'o125;
    load_all();
    run_program("mvi", 1'b0, '0, 1'b0, 1'b0);

    // mvi at last address
    for (int i = 0; i < DEPTH - 1; i++) mem_m[i] = rand_word(1'b1);
    mem_m[DEPTH - 1] = 9'o100;
    load_all();
    run_program("boundary", 1'b0, '0, 1'b0, 1'b0);

    // no halt anywhere: PC saturates; then rerun with writes attempted while busy
    for (int i = 0; i < DEPTH; i++) mem_m[i] = rand_word(1'b1);
    mem_m[DEPTH - 1] = 9'o012;
    load_all();
    run_program("saturate", 1'b0, '0, 1'b0, 1'b0);
    run_program("ld_busy", 1'b0, '0, 1'b1, 1'b0);
    run_program("ld_rerun", 1'b0, '0, 1'b0, 1'b1);

    // random programs with random Done timing and spurious Done in FETCH
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = rand_word(1'b0);
      load_all();
      run_program($sformatf("rand%0d", t), 1'b0, '0, 1'b0, 1'b1);
    end

    // async reset in WAIT
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 9'o700;
    mem_m[0] = 9'o034;
    load_all();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_run("arst");
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("arst_run", 32'(Run), 0);
    chk("arst_busy", 32'(Busy), 0);
    chk("arst_pc", 32'(PC), 0);
    chk("arst_din", 32'(DIN), 0);
    chk("arst_state", 32'(DbgState), 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Done never arrives
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_run("hold");
    cnt = 0;
    while (Run && cnt < 150) begin
      cnt++;
      @(negedge Clock);
    end
`ifdef INSTR_FEEDER_WATCHDOG_EN
    chk("wd_cycles", cnt, 64);
    chk("wd_error", 32'(Error), 1);
    chk("wd_halted", 32'(Halted), 1);
    chk("wd_pc", 32'(PC), 0);
`else
    chk("hold_cycles", cnt, 150);
    chk("hold_run", 32'(Run), 1);
    chk("hold_error", 32'(Error), 0);
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Program sequencer that sits directly upstream of the 9-bit bus processor.
- Holds a small loadable program memory and a program counter (PC).
- Fetches each instruction word and drives it onto the processor's DIN input with Run asserted.
- Waits for the processor's Done, then advances PC; mvi instructions are delivered as an instruction word followed by an immediate word.

Parameters:
- N, 9, instruction/data word width; matches the processor DIN width.
- DEPTH, 32, number of program memory words.
- AW, 5, address width; must satisfy 2**AW >= DEPTH.
- TIMEOUT, 64, maximum WAIT cycles before an error is flagged (only used with the optional feature).

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; begins execution at PC=0.
- LdEn  in  1  program memory write enable.
- LdAddr  in  AW  program memory write address.
- LdData  in  N  program memory write data.
- DIN  out  N  word presented to the processor.
- Run  out  1  request to the processor; high while a word is offered.
- Done  in  1  processor completion strobe.
- PC  out  AW  current program counter.
- Busy  out  1  high in FETCH, DECODE, FETCH_IMM, ISSUE and WAIT.
- Halted  out  1  high in HALT.
- Error  out  1  sticky error flag; cleared only by Reset or Start.

Behaviour:
- Clock and reset: one clock (Clock); reset is asynchronous and active-high (Reset).
- Reset values: DIN=0, Run=0, PC=0, Busy=0, Halted=0, Error=0, state=IDLE. Memory contents are not reset.
- Memory: synchronous write on LdEn. Synchronous read with 1-cycle latency.
- Load rules:
  - Writes are accepted only in IDLE or HALT; LdEn in any other state is ignored.
  - Writes with LdAddr >= DEPTH are ignored.
- Opcode: word[8:6].
  - 3'b001 = mvi, 2 words long.
  - 3'b111 = halt, never forwarded to the processor.
  - Every other opcode is 1 word long.
- States:
  - IDLE: Start -> FETCH, PC<=0, Error<=0.
  - FETCH: read address = PC. -> DECODE.
  - DECODE:
    - halt opcode -> HALT.
    - mvi with PC==DEPTH-1 -> HALT, Error<=1 (missing immediate).
    - mvi otherwise -> FETCH_IMM; instruction word is latched; read address = PC+1.
    - all other opcodes -> ISSUE.
  - FETCH_IMM: immediate word is latched. -> ISSUE.
  - ISSUE: DIN<=instruction word, Run<=1. -> WAIT.
  - WAIT:
    - Run is held at 1.
    - For mvi, DIN<=immediate word from the first WAIT cycle onward; for all other opcodes DIN holds the instruction word.
    - On Done=1: Run<=0, PC<=PC+len.
    - If PC+len > DEPTH-1 -> HALT, and PC saturates at DEPTH-1 (no wrap).
    - Otherwise -> FETCH.
  - HALT: Halted=1, Run=0. Start -> FETCH, PC<=0, Error<=0.
- Latency:
  - Start sampled at edge k gives Run=1 after edge k+3 (1-word instruction) or edge k+4 (mvi).
  - Done sampled high at edge j gives Run=0 after edge j. The next Run rises after edge j+3 at the earliest.
- Ignored inputs:
  - Done outside WAIT is ignored.
  - Start while Busy is ignored.
- Simultaneous events:
  - Start and LdEn together in IDLE: the write completes and execution starts. The first fetch occurs the following cycle and sees the new data.
  - Done in the same cycle as a Run rise cannot occur, because WAIT is entered only after ISSUE.
- Reset mid-operation: all state returns to reset values immediately, with Run dropping asynchronously.

Optional Feature:
- Macro: INSTR_FEEDER_WATCHDOG_EN.
- With the macro defined:
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If TIMEOUT cycles elapse without Done: Run<=0, Error<=1, -> HALT, and PC holds the faulting address.
- Without the macro defined: no counter is built, WAIT lasts indefinitely, and Error is set only by the missing-immediate case.

Test Plan:
- Reset release: check all outputs are 0. Load mem[0]=9'o012 (add), mem[1]=9'o700 (halt), pulse Start. Expect DIN=9'o012, Run=1 after 3 edges. Drive Done after 3 cycles: Run drops, PC=1, then Halted=1 with Run never re-asserted.
- mvi: mem[0]=9'o100, mem[1]=9'o125, mem[2]=9'o700. Expect DIN=9'o100 for the ISSUE cycle, then 9'o125 until Done. Then PC=2 and HALT.
- Boundary: mem[31]=9'o100 (mvi at last address), entered via mem[0..30] = 31 single-word instructions each acknowledged by Done. Expect HALT with Error=1, and 9'o100 never presented on DIN.
- Saturation: mem[31]=9'o012 with no halt word anywhere. After Done, expect PC=31, Halted=1, and no wrap to 0.
- Ignored inputs: LdEn while Busy does not change memory (check by reload and rerun). A spurious Done in FETCH does not advance PC.
- Async Reset asserted in WAIT: Run falls without a clock edge and the state returns to IDLE. With INSTR_FEEDER_WATCHDOG_EN and TIMEOUT=64 and Done held low, expect Error=1 and HALT after 64 WAIT cycles.
